// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter sitting beside data memory.
//
// Stores to TX_DATA (BASE_ADDR+0) queue a byte in a small FIFO; an FSM
// sends each byte as an 8N1 frame, LSB first. STATUS (BASE_ADDR+4) reads as
// {28'b0, overflow, fifo_empty, fifo_full, busy}. A store to STATUS with
// bit 3 set clears the sticky overflow flag.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (frame becomes 11 bit periods).
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   Mem_Write_i   store strobe from the control unit
//   Mem_Read_i    load strobe from the control unit
//   Address_i     byte address (ALU result)
//   Write_Data_i  store data (rs2)
//   Read_Data_o   load data, combinational
//   Sel_o         address falls in this block's 8-byte window, combinational
//   Tx_o          serial line, registered, idles high
//   Busy_o        FSM active or FIFO non-empty, combinational
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0100,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Write_i,
  input  logic        Mem_Read_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_Data_i,
  output logic [31:0] Read_Data_o,
  output logic        Sel_o,
  output logic        Tx_o,
  output logic        Busy_o
);

  localparam int unsigned IDX_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;
`endif

  // Registers
  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif
  logic [7:0]        mem_q [FIFO_DEPTH];

  // Combinational helpers
  logic       sel_c;
  logic       wr_data_c;
  logic       wr_stat_c;
  logic       fifo_empty_c;
  logic       fifo_full_c;
  logic       push_c;
  logic       pop_c;
  logic [7:0] head_c;
  logic       unused_bits_c;

  // Address decode: 8-byte window, bit 2 picks the register, bits 1:0 ignored
  assign sel_c     = (Address_i[31:3] == BASE_ADDR[31:3]);
  assign Sel_o     = sel_c;
  assign wr_data_c = Mem_Write_i & sel_c & ~Address_i[2];
  assign wr_stat_c = Mem_Write_i & sel_c &  Address_i[2];

  assign unused_bits_c = ^{Address_i[1:0], Write_Data_i[31:8]};

  // FIFO status from extended pointers
  assign fifo_empty_c = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_c  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                        (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

  // Full is judged before any same-edge pop, so a full FIFO never accepts
  assign push_c = wr_data_c & ~fifo_full_c;
  assign head_c = mem_q[rd_ptr_q[IDX_W-1:0]];

  // FIFO pointers and sticky overflow flag
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    ovf_d    = ovf_q;
    if (wr_data_c && fifo_full_c) begin
      ovf_d = 1'b1;
    end else if (wr_stat_c && Write_Data_i[3]) begin
      ovf_d = 1'b0;
    end
  end

  // FIFO storage; contents are don't-care until the write pointer passes them
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= Write_Data_i[7:0];
    end
  end

  // Transmit FSM next-state and line value
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    pop_c    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty_c) begin
          pop_c   = 1'b1;
          shift_d = head_c;
          baud_d  = BAUD_RELOAD;
          tx_d    = 1'b0;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head_c;
`endif
        end
      end

      ST_START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          tx_d    = shift_q[0];
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end

      ST_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            // Next bit comes from shift_q[1] since the shift lands this edge
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
`endif

      ST_STOP: begin
        tx_d = 1'b1;
        if (baud_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any frame and drops queued bytes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign Tx_o   = tx_q;
  assign Busy_o = (state_q != ST_IDLE) | ~fifo_empty_c;

  // Load path: only STATUS returns data
  always_comb begin
    Read_Data_o = '0;
    if (Mem_Read_i && sel_c && Address_i[2]) begin
      Read_Data_o = {28'b0, ovf_q, fifo_empty_c, fifo_full_c, Busy_o};
    end
  end

endmodule
